// File: rtl/pcileech_rw1c_event_collector.sv
// Event collector feeding the RW1C status register: captures event pulses, coalesces them
// over a HOLDOFF window and issues one set-update. Optional IRQ: PCILEECH_EVT_COLLECTOR_IRQ_EN.
module pcileech_rw1c_event_collector #(
  parameter int WIDTH   = 32,
  parameter int HOLDOFF = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] evt_in,
  input  logic [WIDTH-1:0] evt_enable,
  input  logic [WIDTH-1:0] reg_value,
  input  logic [WIDTH-1:0] lost_clr,
  output logic             hw_set_en,
  output logic [WIDTH-1:0] hw_set_data,
  output logic [WIDTH-1:0] hw_set_mask,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] lost_evt,
  output logic [CNT_W-1:0] upd_count,
  output logic             busy,
  output logic             irq_req,
  input  logic             irq_ack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam bit         HAS_HOLD  = (HOLDOFF > 0);
  localparam logic [7:0] HOLD_INIT = HAS_HOLD ? 8'(HOLDOFF - 1) : 8'd0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic [WIDTH-1:0] lost_q, lost_d;
  logic             set_en_q, set_en_d;
  logic [WIDTH-1:0] set_data_q, set_data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             irq_q, irq_d;
  logic [WIDTH-1:0] cap;
  logic [WIDTH-1:0] new_lost;

  always_comb begin
    cap        = evt_in & evt_enable;
    // Events landing on the ISSUE cycle open the next window rather than being lost.
    new_lost   = (state_q == ST_ISSUE) ? '0 : (cap & pending_q);
    lost_d     = (lost_q & ~lost_clr) | new_lost;
    pending_d  = pending_q | cap;
    state_d    = state_q;
    timer_d    = timer_q;
    set_en_d   = 1'b0;
    set_data_d = '0;
    cnt_d      = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if ((pending_q | cap) != '0) begin
          if (HAS_HOLD) begin
            state_d = ST_HOLD;
            timer_d = HOLD_INIT;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_HOLD: begin
        if (timer_q == 8'd0) state_d = ST_ISSUE;
        else                 timer_d = timer_q - 8'd1;
      end
      ST_ISSUE: begin
        set_en_d   = 1'b1;
        set_data_d = pending_q;
        pending_d  = cap;
        cnt_d      = sat_inc(cnt_q);
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PCILEECH_EVT_COLLECTOR_IRQ_EN
  logic irq_set;
  always_comb begin
    irq_set = (state_q == ST_ISSUE) && ((pending_q & ~reg_value) != '0);
    irq_d   = (irq_q & ~irq_ack) | irq_set;
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_ack, reg_value};
  assign irq_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      pending_q  <= '0;
      lost_q     <= '0;
      set_en_q   <= 1'b0;
      set_data_q <= '0;
      cnt_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      lost_q     <= lost_d;
      set_en_q   <= set_en_d;
      set_data_q <= set_data_d;
      cnt_q      <= cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign hw_set_en   = set_en_q;
  assign hw_set_data = set_data_q;
  assign hw_set_mask = set_data_q;
  assign pending     = pending_q;
  assign lost_evt    = lost_q;
  assign upd_count   = cnt_q;
  assign busy        = (state_q != ST_IDLE);
  assign irq_req     = irq_q;

endmodule

// File: doc/pcileech_rw1c_event_collector.md
Name: pcileech_rw1c_event_collector

Overview:
- Upstream stage of the RW1C status register; sole driver of its hw_set_en / hw_set_data / hw_set_mask inputs.
- Captures single-cycle hardware event pulses (error/status sources) into a pending vector.
- Coalesces pending events over a programmable hold-off window, then issues one set-update to the register.
- Tracks events lost to coalescing and counts issued updates for diagnostics.

Parameters:
- WIDTH, 32: event/register width in bits.
- HOLDOFF, 16: coalescing window in clk cycles, range 0..255; 0 = issue on the cycle after capture.
- CNT_W, 16: width of issued-update counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- evt_in  in  WIDTH  event pulses; bit i high for one cycle = one event on source i.
- evt_enable  in  WIDTH  per-bit enable; disabled bits are ignored at capture.
- reg_value  in  WIDTH  current value of the downstream RW1C register.
- lost_clr  in  WIDTH  write-1-to-clear strobe for lost_evt.
- hw_set_en  out  1  one-cycle update strobe to the register.
- hw_set_data  out  WIDTH  bits to set.
- hw_set_mask  out  WIDTH  equal to hw_set_data.
- pending  out  WIDTH  captured events not yet issued.
- lost_evt  out  WIDTH  sticky: event arrived on an already-pending bit.
- upd_count  out  CNT_W  number of issued updates; saturates at all-ones.
- busy  out  1  high in HOLD or ISSUE.
- irq_req  out  1  new-status notification (optional feature).
- irq_ack  in  1  acknowledge for irq_req.

Behaviour:
- Reset: all outputs 0; pending, lost_evt, and timer cleared; FSM = IDLE. Reset mid-HOLD or mid-ISSUE discards pending; no strobe is issued.
- Capture each cycle: cap = evt_in & evt_enable. pending |= cap. lost_evt |= cap & pending (pending before this cycle's OR).
- lost_evt update: lost_evt <= (lost_evt & ~lost_clr) | new_lost. A set in the same cycle beats the clear.
- FSM states: IDLE, HOLD, ISSUE.
- IDLE:
  - If (pending | cap) != 0 and HOLDOFF > 0: go to HOLD, timer = HOLDOFF-1.
  - If (pending | cap) != 0 and HOLDOFF == 0: go to ISSUE.
- HOLD:
  - Timer decrements each cycle; captures continue to OR into pending.
  - At timer == 0: go to ISSUE.
- ISSUE:
  - Registered outputs: hw_set_en = 1 for exactly one cycle; hw_set_data = hw_set_mask = pending.
  - Next state of pending = cap of that cycle only; those events are not lost, they start a new window.
  - upd_count += 1, saturating.
  - Go to IDLE.
- Latency: first event to hw_set_en = HOLDOFF + 2 cycles (HOLDOFF=0: 2 cycles).
- busy = (state != IDLE).
- Bits already set in reg_value are still issued; OR into the register is idempotent.
- evt_enable deasserted while a bit is pending: the bit stays pending and is issued.
- hw_set_en is never high on two consecutive cycles.

Optional Feature:
- Macro: PCILEECH_EVT_COLLECTOR_IRQ_EN.
- Enabled:
  - On an ISSUE cycle where (pending & ~reg_value) != 0, set irq_req the following cycle.
  - irq_req holds until sampled with irq_ack = 1, then clears the next cycle.
  - Further qualifying ISSUEs while irq_req is high coalesce; no second request is queued.
  - irq_ack while irq_req is low is ignored.
  - Reset clears irq_req.
- Disabled: irq_req tied 0; irq_ack unused.

Test Plan:
- HOLDOFF=16; single pulse evt_in=0x1 at cycle 0 -> hw_set_en high at cycle 18 only, data=mask=0x00000001; upd_count=1; busy low by cycle 19.
- HOLDOFF=16; pulses 0x1 at cycle 0, 0x4 at cycle 5, 0x1 at cycle 9 -> one strobe with data 0x00000005; lost_evt=0x00000001; lost_clr=0x1 then clears it.
- HOLDOFF=4; pulse 0x2 on the ISSUE cycle of a prior window -> first strobe excludes 0x2; second strobe data=0x00000002 six cycles later; lost_evt stays 0.
- evt_enable=0xFFFFFFFE, evt_in=0x3 -> strobe data 0x00000002; HOLDOFF=0 gives strobe exactly 2 cycles after the pulse.
- rst asserted during HOLD with pending=0x10 -> no strobe; pending=0, upd_count and lost_evt unchanged from 0; FSM IDLE.
- IRQ_EN, reg_value=0x0, issue 0x8 -> irq_req high until irq_ack; second issue of 0x8 with reg_value=0x8 -> no irq_req. Force upd_count to 0xFFFF -> stays 0xFFFF after issue.
